// File: rtl/bcd_stopwatch_timer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_stopwatch_timer
// Purpose  : N-digit BCD stopwatch / countdown timer with debounced buttons,
//            lap freeze and multiplexed active-low 7-segment drive.
// Revision : 1.0  initial release
// ============================================================================
module bcd_stopwatch_timer #(
  parameter int N_DIGITS     = 4,
  parameter int TICK_DIV     = 100000,
  parameter int SCAN_DIV     = 100000,
  parameter int DEBOUNCE_CYC = 500000,
  parameter int DP_POS       = 3
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  btn_start,
  input  logic                  btn_lap,
  input  logic                  btn_clr,
  input  logic                  mode_down,
  input  logic [4*N_DIGITS-1:0] load_val,
  output logic [N_DIGITS-1:0]   an,
  output logic [7:0]            seg,
  output logic                  running,
  output logic                  done
);

  localparam int DW  = 4 * N_DIGITS;
  localparam int DBW = $clog2(DEBOUNCE_CYC + 1);
  localparam int PW  = $clog2(TICK_DIV);
  localparam int SW  = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(N_DIGITS);
  localparam logic [N_DIGITS-1:0] DP_MASK =
    (DP_POS < N_DIGITS) ? (N_DIGITS'(1) << DP_POS) : '0;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  function automatic logic [DW-1:0] bcd_inc(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (c) begin
        if (v[4*i +: 4] == 4'd9) r[4*i +: 4] = 4'd0;
        else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_dec(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    logic          b;
    r = v;
    b = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (b) begin
        if (v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'd9;
        else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] bcd_clamp(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < N_DIGITS; i++)
      r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h40;  4'd1: seg7 = 7'h79;  4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;  4'd4: seg7 = 7'h19;  4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;  4'd7: seg7 = 7'h78;  4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;  default: seg7 = 7'h7F;
    endcase
  endfunction

  // Each raw button: 2-flop sync, stability filter, registered rising-edge pulse
  logic [2:0] raw, pulse;
  assign raw = {btn_clr, btn_lap, btn_start};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic           s1, s2, stable, stable_d, pulse_q;
    logic [DBW-1:0] cnt;
    always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
        s1 <= 1'b0; s2 <= 1'b0; stable <= 1'b0; stable_d <= 1'b0;
        pulse_q <= 1'b0; cnt <= '0;
      end else begin
        s1       <= raw[b];
        s2       <= s1;
        stable_d <= stable;
        pulse_q  <= stable & ~stable_d;
        if (s2 == stable) cnt <= '0;
        else if (cnt == DBW'(DEBOUNCE_CYC - 1)) begin
          stable <= s2;
          cnt    <= '0;
        end else cnt <= cnt + 1'b1;
      end
    end
    assign pulse[b] = pulse_q;
  end

  logic start_p, lap_p, clr_p;
  assign start_p = pulse[0];
  assign lap_p   = pulse[1];
  assign clr_p   = pulse[2];

  state_t        state, state_nx;
  logic [DW-1:0] count, snap, load_c, count_dec;
  logic [PW-1:0] presc;
  logic          mode_q, freeze, tick;

  assign load_c    = bcd_clamp(load_val);
  assign count_dec = bcd_dec(count);
  assign tick      = (state == RUN) && (presc == PW'(TICK_DIV - 1));
  assign running   = (state == RUN);
  assign done      = (state == DONE);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_p) state_nx = (mode_down && load_c == '0) ? DONE : RUN;
      RUN: begin
        if (tick && mode_q && count_dec == '0) state_nx = DONE;
        else if (start_p)                      state_nx = PAUSE;
      end
      PAUSE:   if (start_p) state_nx = RUN;
      default: state_nx = state;
    endcase
    if (clr_p) state_nx = IDLE;
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      snap   <= '0;
      presc  <= '0;
      mode_q <= 1'b0;
      freeze <= 1'b0;
    end else begin
      if (state == IDLE) count <= mode_down ? load_c : '0;
      else if (state == DONE) count <= '0;
      else if (tick) begin
        if (!mode_q)          count <= bcd_inc(count);
        else if (count != '0) count <= count_dec;
      end

      if (state == IDLE && start_p && !clr_p) mode_q <= mode_down;

      if (clr_p || state == IDLE) presc <= '0;
      else if (state == RUN)      presc <= tick ? '0 : presc + 1'b1;

      // Start outranks lap, so a lap arriving with a pause is dropped
      if (clr_p || state_nx == DONE) freeze <= 1'b0;
      else if (state == RUN && lap_p && !start_p) begin
        freeze <= ~freeze;
        if (!freeze) snap <= count;
      end
    end
  end

  logic [SW-1:0]       scan_cnt;
  logic [IW-1:0]       idx;
  logic [DW-1:0]       disp;
  logic [3:0]          cur_digit;
  logic [N_DIGITS-1:0] an_nx;

  assign disp      = freeze ? snap : count;
  assign cur_digit = disp[4*idx +: 4];
  assign an_nx     = ~(N_DIGITS'(1) << idx);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= '1;
      seg      <= 8'hFF;
    end else begin
      if (scan_cnt == SW'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      end else scan_cnt <= scan_cnt + 1'b1;
      an  <= an_nx;
      seg <= {~|(DP_MASK & ~an_nx), seg7(cur_digit)};
    end
  end

endmodule
`default_nettype wire
